// File: rtl/st7735_pkg.sv
// Shared definitions for the ST7735 bring-up sequencer and the pixel streamer.
package st7735_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RST_LO,
        ST_RST_HI,
        ST_LOAD,
        ST_SEND,
        ST_DRAIN,
        ST_DELAY,
        ST_FIN,
        ST_DONE
    } st7735_state_e;

    localparam logic [7:0] CMD_SWRESET = 8'h01;
    localparam logic [7:0] CMD_SLPOUT  = 8'h11;
    localparam logic [7:0] CMD_DISPON  = 8'h29;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/st7735_init_seq.sv
// ST7735 bring-up: pulses the panel reset pin, streams the init ROM through the
// SPI byte transmitter, inserts the datasheet waits after SWRESET/SLPOUT/DISPON
// and then raises a sticky done so the pixel streamer can take the transmitter.
module st7735_init_seq
    import st7735_pkg::*;
#(
    parameter int unsigned N          = 22,
    parameter int unsigned N_USED     = 19,
    parameter int unsigned RST_LO_CYC = 1_000,
    parameter int unsigned RST_HI_CYC = 12_000_000,
    parameter int unsigned SWRST_CYC  = 15_000_000,
    parameter int unsigned SLPOUT_CYC = 50_000_000,
    parameter int unsigned DISPON_CYC = 10_000_000,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic [IW-1:0] rom_idx,
    input  logic          rom_is_data,
    input  logic [7:0]    rom_byte,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic [7:0]    tx_byte,
    output logic          tx_dc,
    input  logic          tx_busy,
    output logic          lcd_rst_n,
    output logic          busy,
    output logic          done
);

    localparam int unsigned MAX_CYC = max_u(max_u(max_u(RST_LO_CYC, RST_HI_CYC),
                                                  max_u(SWRST_CYC, SLPOUT_CYC)), DISPON_CYC);
    localparam int unsigned CW = $clog2(MAX_CYC) + 1;

    st7735_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          tx_valid_q, tx_valid_d;
    logic [7:0]    tx_byte_q, tx_byte_d;
    logic          tx_dc_q, tx_dc_d;
    logic          lcd_rst_n_q, lcd_rst_n_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          advance;

    assign rom_idx   = idx_q;
    assign tx_valid  = tx_valid_q;
    assign tx_byte   = tx_byte_q;
    assign tx_dc     = tx_dc_q;
    assign lcd_rst_n = lcd_rst_n_q;
    assign busy      = busy_q;
    assign done      = done_q;

    // Next-state, shared delay counter, ROM walk and registered output values.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        tx_valid_d = tx_valid_q;
        tx_byte_d  = tx_byte_q;
        tx_dc_d    = tx_dc_q;
        advance    = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RST_LO;
                    cnt_d   = CW'(RST_LO_CYC);
                    idx_d   = '0;
                end
            end
            ST_RST_LO: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q <= CW'(1)) begin
                    state_d = ST_RST_HI;
                    cnt_d   = CW'(RST_HI_CYC);
                end
            end
            // The LOAD cycle is the last cycle of the post-reset wait, so leave one early.
            ST_RST_HI: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q <= CW'(2)) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end
            end
            ST_LOAD: begin
                tx_byte_d  = rom_byte;
                tx_dc_d    = rom_is_data;
                tx_valid_d = 1'b1;
                state_d    = ST_SEND;
            end
            ST_SEND: begin
                if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = ST_DRAIN;
                end
            end
            // tx_byte/tx_dc still hold the byte just sent; only commands trigger waits.
            ST_DRAIN: begin
                if (!tx_busy) begin
                    if (!tx_dc_q && tx_byte_q == CMD_SWRESET) begin
                        cnt_d   = CW'(SWRST_CYC);
                        state_d = ST_DELAY;
                    end else if (!tx_dc_q && tx_byte_q == CMD_SLPOUT) begin
                        cnt_d   = CW'(SLPOUT_CYC);
                        state_d = ST_DELAY;
                    end else if (!tx_dc_q && tx_byte_q == CMD_DISPON) begin
                        cnt_d   = CW'(DISPON_CYC);
                        state_d = ST_DELAY;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            // A zero-length wait still spends this one cycle here.
            ST_DELAY: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q <= CW'(1)) begin
                    cnt_d   = '0;
                    advance = 1'b1;
                end
            end
            ST_FIN: begin
                state_d = ST_DONE;
                idx_d   = '0;
            end
            default: state_d = ST_IDLE;
        endcase

        if (advance) begin
            if (idx_q == IW'(N_USED - 1)) begin
                state_d = ST_FIN;
            end else begin
                idx_d   = idx_q + IW'(1);
                state_d = ST_LOAD;
            end
        end

        lcd_rst_n_d = (state_d != ST_RST_LO);
        busy_d      = (state_d != ST_IDLE) && (state_d != ST_DONE);
        done_d      = (state_d == ST_DONE);
    end

    // State and output registers; rst aborts any state immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            tx_valid_q  <= 1'b0;
            tx_byte_q   <= 8'h00;
            tx_dc_q     <= 1'b0;
            lcd_rst_n_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            tx_valid_q  <= tx_valid_d;
            tx_byte_q   <= tx_byte_d;
            tx_dc_q     <= tx_dc_d;
            lcd_rst_n_q <= lcd_rst_n_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

endmodule
